// File: rtl/enemy_pkg.sv
// Shared enemy/player/bullet definitions: slot state encoding, play-field bounds and sprite constants.
package enemy_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DYING  = 2'd2
    } slot_state_e;

    localparam logic [7:0]  TRANSP     = 8'hBB;
    localparam int unsigned BOUND_UP   = 31;
    localparam int unsigned BOUND_DOWN = 511;
    localparam int unsigned SPR        = 16;

endpackage

// File: rtl/enemy_wave_rom.sv
// 16x16 enemy sprite ROM, 8-bit colour, one-cycle registered read; colour is {row, col}.
module enemy_wave_rom
    import enemy_pkg::*;
(
    input  logic       clk,
    input  logic [7:0] addr,
    output logic [7:0] data
);

    logic [7:0] data_d;
    logic [7:0] data_q;

    always_comb begin
        data_d = {addr[7:4], addr[3:0]};
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/enemy_wave_array.sv
// Wave of NUM_EN descending enemy slots: staggered spawn, per-slot IDLE/ACTIVE/DYING FSM,
// shared sprite ROM for drawing, collision and escape event pulses.
module enemy_wave_array
    import enemy_pkg::*;
#(
    parameter int unsigned NUM_EN     = 4,
    parameter int unsigned X_START    = 208,
    parameter int unsigned X_STEP     = 100,
    parameter int unsigned BOUND_UP   = enemy_pkg::BOUND_UP,
    parameter int unsigned BOUND_DOWN = enemy_pkg::BOUND_DOWN,
    parameter int unsigned SPR        = enemy_pkg::SPR,
    parameter logic [7:0]  TRANSP     = enemy_pkg::TRANSP,
    parameter int unsigned SPAWN_GAP  = 40,
    parameter int unsigned DIE_FRAMES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pause,
    input  logic              game_start_on,
    input  logic              game_over_on,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              p_on,
    input  logic              hit_w_enemy,
    input  logic [23:0]       wave_speed,
    output logic [NUM_EN-1:0] active_mask,
    output logic              e_w_on,
    output logic [7:0]        rgb,
    output logic              kill_pulse,
    output logic              escape_pulse
);

    localparam int unsigned IDX_W = (NUM_EN > 1) ? $clog2(NUM_EN) : 1;
    localparam int unsigned GAP_W = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
    localparam int unsigned DIE_W = (DIE_FRAMES > 1) ? $clog2(DIE_FRAMES) : 1;

    function automatic int unsigned slot_x(input int unsigned i);
        return X_START + i * X_STEP;
    endfunction

    logic [23:0]      div_q, div_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    slot_state_e      state_q [NUM_EN];
    slot_state_e      state_d [NUM_EN];
    logic [9:0]       y_q     [NUM_EN];
    logic [9:0]       y_d     [NUM_EN];
    logic [DIE_W-1:0] die_q   [NUM_EN];
    logic [DIE_W-1:0] die_d   [NUM_EN];
    logic             range_q, range_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             kill_q, kill_d;
    logic             esc_q, esc_d;

    logic             tick, move_en, spawn_en, collide;
    logic             free_any;
    logic [IDX_W-1:0] free_idx;
    logic [3:0]       row, col;
    logic [7:0]       rom_rgb;

    enemy_wave_rom u_rom (
        .clk  (clk),
        .addr ({row, col}),
        .data (rom_rgb)
    );

    // Draw: lowest-index ACTIVE slot covering (x,y) owns the pixel
    always_comb begin
        range_d = 1'b0;
        idx_d   = '0;
        row     = '0;
        col     = '0;
        for (int unsigned i = 0; i < NUM_EN; i++) begin
            if (!range_d && state_q[i] == ACTIVE
                && 32'(x) >= slot_x(i) && 32'(x) < slot_x(i) + SPR
                && 32'(y) >= 32'(y_q[i]) && 32'(y) < 32'(y_q[i]) + SPR) begin
                range_d = 1'b1;
                idx_d   = IDX_W'(i);
                col     = 4'(32'(x) - slot_x(i));
                row     = 4'(y - y_q[i]);
            end
        end
    end

    assign e_w_on = range_q && (rom_rgb != TRANSP);
    assign rgb    = range_q ? rom_rgb : '0;

    always_comb begin
        active_mask = '0;
        for (int unsigned i = 0; i < NUM_EN; i++) begin
            active_mask[i] = (state_q[i] == ACTIVE);
        end
    end

    always_comb begin
        tick     = (div_q == '0);
        move_en  = tick && !pause;
        spawn_en = move_en && !game_start_on && !game_over_on;
        collide  = e_w_on && (p_on || hit_w_enemy);

        div_d = div_q;
        if (!pause) begin
            div_d = (div_q >= wave_speed) ? '0 : div_q + 24'd1;
        end

        free_any = 1'b0;
        free_idx = '0;
        for (int unsigned i = 0; i < NUM_EN; i++) begin
            if (!free_any && state_q[i] == IDLE) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end

        gap_d = gap_q;
        if (spawn_en) begin
            if (gap_q == GAP_W'(SPAWN_GAP - 1)) begin
                gap_d = free_any ? '0 : gap_q;
            end else begin
                gap_d = gap_q + 1'b1;
            end
        end

        kill_d = 1'b0;
        esc_d  = 1'b0;
        for (int unsigned i = 0; i < NUM_EN; i++) begin
            state_d[i] = state_q[i];
            y_d[i]     = y_q[i];
            die_d[i]   = die_q[i];
            unique case (state_q[i])
                IDLE: begin
                    if (spawn_en && gap_q == GAP_W'(SPAWN_GAP - 1) && free_idx == IDX_W'(i)) begin
                        state_d[i] = ACTIVE;
                        y_d[i]     = 10'(BOUND_UP);
                    end
                end
                ACTIVE: begin
                    // Collision outranks escape, so a hit on the last line is only a kill
                    if (collide && idx_q == IDX_W'(i)) begin
                        state_d[i] = DYING;
                        die_d[i]   = '0;
                        kill_d     = 1'b1;
                    end else if (move_en) begin
                        if (y_q[i] >= 10'(BOUND_DOWN - 1)) begin
                            state_d[i] = IDLE;
                            y_d[i]     = 10'(BOUND_UP);
                            esc_d      = 1'b1;
                        end else begin
                            y_d[i] = y_q[i] + 10'd1;
                        end
                    end
                end
                DYING: begin
                    if (frame_start && !pause) begin
                        if (die_q[i] == DIE_W'(DIE_FRAMES - 1)) begin
                            state_d[i] = IDLE;
                            y_d[i]     = 10'(BOUND_UP);
                            die_d[i]   = '0;
                        end else begin
                            die_d[i] = die_q[i] + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            gap_q   <= '0;
            range_q <= 1'b0;
            idx_q   <= '0;
            kill_q  <= 1'b0;
            esc_q   <= 1'b0;
            for (int unsigned i = 0; i < NUM_EN; i++) begin
                state_q[i] <= IDLE;
                y_q[i]     <= 10'(BOUND_UP);
                die_q[i]   <= '0;
            end
        end else begin
            div_q   <= div_d;
            gap_q   <= gap_d;
            range_q <= range_d;
            idx_q   <= idx_d;
            kill_q  <= kill_d;
            esc_q   <= esc_d;
            for (int unsigned i = 0; i < NUM_EN; i++) begin
                state_q[i] <= state_d[i];
                y_q[i]     <= y_d[i];
                die_q[i]   <= die_d[i];
            end
        end
    end

    assign kill_pulse   = kill_q;
    assign escape_pulse = esc_q;

endmodule

// File: tb/tb_enemy_wave_array.sv
// Directed bench for enemy_wave_array: spawn timing, descent, escape, kill/dying, pause phase,
// game-over inhibit and mid-descent reset, with a pixel scoreboard.
`timescale 1ns/1ps
module tb_enemy_wave_array;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start, pause, game_start_on, game_over_on;
    logic [9:0]  x, y;
    logic        p_on, hit_w_enemy;
    logic [23:0] wave_speed;
    logic [3:0]  active_mask;
    logic        e_w_on;
    logic [7:0]  rgb;
    logic        kill_pulse, escape_pulse;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        string      tag;
        logic [8:0] exp;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    enemy_wave_array #(
        .NUM_EN     (4),
        .X_START    (208),
        .X_STEP     (100),
        .BOUND_UP   (31),
        .BOUND_DOWN (511),
        .SPR        (16),
        .TRANSP     (8'hBB),
        .SPAWN_GAP  (40),
        .DIE_FRAMES (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .pause         (pause),
        .game_start_on (game_start_on),
        .game_over_on  (game_over_on),
        .x             (x),
        .y             (y),
        .p_on          (p_on),
        .hit_w_enemy   (hit_w_enemy),
        .wave_speed    (wave_speed),
        .active_mask   (active_mask),
        .e_w_on        (e_w_on),
        .rgb           (rgb),
        .kill_pulse    (kill_pulse),
        .escape_pulse  (escape_pulse)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_to(input int e);
        if (e > cyc) tick(e - cyc);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pixel request: expectation queued when (x,y) is driven, compared one clock later
    task automatic probe(input string tag, input int px, input int py,
                         input logic on, input logic [7:0] c);
        exp_t e;
        x = 10'(px);
        y = 10'(py);
        sb.push_back('{tag, {on, c}});
        tick(1);
        e = sb.pop_front();
        check(e.tag, {7'd0, e_w_on, rgb}, {7'd0, e.exp});
        x = '0;
        y = '0;
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        tick(1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mask"}, 16'(active_mask), 16'h0);
        check({tag, "_on"},   16'(e_w_on), 16'h0);
        check({tag, "_rgb"},  16'(rgb), 16'h0);
        check({tag, "_kill"}, 16'(kill_pulse), 16'h0);
        check({tag, "_esc"},  16'(escape_pulse), 16'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [3:0] prev_mask;
        int  n;
        int  esc_n;
        logic grew;

        rst = 1'b1;
        frame_start = 1'b0; pause = 1'b0; game_start_on = 1'b0; game_over_on = 1'b0;
        x = '0; y = '0; p_on = 1'b0; hit_w_enemy = 1'b0; wave_speed = '0;
        tick(3);
        check_idle_outputs("reset");

        // ---- staggered spawn and per-clock descent ----
        rst = 1'b0;
        cyc = 0;
        run_to(39);  check("mask_before_spawn0", 16'(active_mask), 16'h0);
        run_to(40);  check("mask_spawn0", 16'(active_mask), 16'h1);
        probe("pix_slot0_y31", 210, 35, 1'b1, 8'h42);
        probe("pix_slot0_y32", 210, 35, 1'b1, 8'h32);
        run_to(79);  check("mask_before_spawn1", 16'(active_mask), 16'h1);
        run_to(80);  check("mask_spawn1", 16'(active_mask), 16'h3);

        // ---- slot0 reaches y=510 and escapes ----
        run_to(519); check("mask_pre_escape", 16'(active_mask), 16'hF);
                     check("esc_pre", 16'(escape_pulse), 16'h0);
        run_to(520); check("esc_pulse", 16'(escape_pulse), 16'h1);
                     check("mask_escaped", 16'(active_mask), 16'hE);
        run_to(521); check("esc_one_cycle", 16'(escape_pulse), 16'h0);
                     check("mask_respawn0", 16'(active_mask), 16'hF);
        probe("pix_respawn_y31", 208, 31, 1'b1, 8'h00);
        probe("pix_before_rst", 211, 36, 1'b1, 8'h43);

        // ---- reset mid-descent ----
        rst = 1'b1;
        tick(1);
        check_idle_outputs("rst_mid");
        tick(2);
        rst = 1'b0;
        cyc = 0;

        // ---- freeze motion with a long divider period, then pixel checks ----
        run_to(120); check("mask_three", 16'(active_mask), 16'h7);
        wave_speed = 24'd1000;
        tick(1);     // last tick for ~1000 clocks: y0=112, y1=72, y2=32
        probe("pix_s0", 211, 117, 1'b1, 8'h53);
        probe("pix_transp", 219, 123, 1'b0, 8'hBB);
        probe("pix_s1_corner", 323, 87, 1'b1, 8'hFF);
        probe("pix_x_outside", 324, 72, 1'b0, 8'h00);
        probe("pix_y_above", 308, 71, 1'b0, 8'h00);
        probe("pix_idle_slot3", 508, 40, 1'b0, 8'h00);

        // ---- bullet hit on slot2 ----
        x = 10'd412; y = 10'd36;
        sb.push_back('{"pix_kill_target", {1'b1, 8'h44}});
        tick(1);
        e = sb.pop_front();
        check(e.tag, {7'd0, e_w_on, rgb}, {7'd0, e.exp});
        hit_w_enemy = 1'b1; x = '0; y = '0;
        tick(1);
        hit_w_enemy = 1'b0;
        check("kill_pulse", 16'(kill_pulse), 16'h1);
        check("mask_killed", 16'(active_mask), 16'h3);
        tick(1);
        check("kill_one_cycle", 16'(kill_pulse), 16'h0);
        probe("pix_dying_hidden", 408, 32, 1'b0, 8'h00);

        // paused frame does not count; seven counted frames leave slot2 DYING
        pause = 1'b1;
        frame_pulse();
        pause = 1'b0;
        repeat (7) frame_pulse();
        wave_speed = '0;
        n = 0;
        while (active_mask == 4'h3 && n < 200) begin tick(1); n++; end
        check("spawn_skips_dying", 16'(active_mask), 16'hB);

        frame_pulse();
        n = 0;
        while (active_mask == 4'hB && n < 200) begin tick(1); n++; end
        pause = 1'b1;
        wave_speed = 24'd3;
        check("respawn_after_die", 16'(active_mask), 16'hF);

        // ---- pause: slot2 frozen at y=31, then resume phase ----
        probe("pause_start", 408, 33, 1'b1, 8'h20);
        tick(100);
        check("pause_mask", 16'(active_mask), 16'hF);
        probe("pause_end", 408, 33, 1'b1, 8'h20);
        pause = 1'b0;
        tick(1);
        for (int i = 0; i < 4; i++) probe("resume_hold", 409, 33, 1'b1, 8'h11);
        probe("resume_step", 409, 33, 1'b1, 8'h01);

        // ---- game over: no respawn, live slots escape ----
        game_over_on = 1'b1;
        wave_speed = '0;
        prev_mask = active_mask;
        esc_n = 0;
        grew = 1'b0;
        n = 0;
        while (active_mask != 4'h0 && n < 1200) begin
            tick(1);
            n++;
            if (escape_pulse) esc_n++;
            if ((active_mask & ~prev_mask) != 4'h0) grew = 1'b1;
            prev_mask = active_mask;
        end
        check("gameover_drained", 16'(active_mask), 16'h0);
        check("gameover_escapes", 16'(esc_n), 16'd4);
        check("gameover_no_spawn", 16'(grew), 16'h0);
        tick(100);
        check("gameover_still_empty", 16'(active_mask), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
